dtcm_lsu: RTL and testbench
===========================

DTCM_LSU -- requirements
Module: dtcm_lsu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and reset is sampled only on the rising edge of clk.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  block accepts the request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is reserved and SHALL be treated as word.
REQ-008 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  load result valid this cycle; stores never produce a response.
REQ-012 rsp_rdata  output  32  extended load result.
REQ-013 mem_addr  output  32  TCM address; the TCM uses bits [11:2].
REQ-014 mem_wen  output  4  TCM byte write enables.
REQ-015 mem_wdata  output  32  TCM write data, lane-aligned.
REQ-016 mem_rdata  input  32  TCM read word, valid one cycle after mem_addr is presented.

Function
REQ-017 Acceptance SHALL occur in cycle N when req_valid and req_ready are both high.
- req_ready = (state == IDLE) and not reset.
REQ-018 In IDLE, mem_addr, mem_wen and mem_wdata SHALL be driven combinationally from the current request in cycle N.
- mem_addr = {req_addr[31:2], 2'b00}.
- mem_wen = 0 unless an accepted store is present.
REQ-019 Alignment SHALL use offset = addr[1:0] and nbytes = 1/2/4 per size.
- An access is split when offset + nbytes > 4.
REQ-020 Store lane data SHALL be formed as the 64-bit value ({32'b0, wdata} << 8*offset), with mask ({4'b0, bytemask} << offset).
- The low 32 bits / low 4 mask bits form the first access.
- The high halves form the second access.
REQ-021 State machine SHALL have two states, IDLE and SECOND.
- IDLE -> SECOND on acceptance of a split request.
- SECOND -> IDLE unconditionally after one cycle.
REQ-022 In SECOND (cycle N+1), the block SHALL:
- drive mem_addr = first word address + 4, using 32-bit wrap-around: 0xFFFFFFFC + 4 = 0x00000000;
- drive the high mask and data halves;
- hold req_ready low.
REQ-023 For a non-split load, rsp_valid SHALL be high in cycle N+1.
- rsp_rdata is taken from mem_rdata shifted right by 8*offset, masked to size, and extended.
REQ-024 For a split load, the first mem_rdata (cycle N+1) SHALL be captured in a hold register, and rsp_valid SHALL be high in cycle N+2.
- rsp_rdata is taken from ({mem_rdata, hold} >> 8*offset), masked and extended.
REQ-025 Non-split loads SHALL be fully pipelined: a new request accepted in N+1 coexists with the response of the request accepted in N.
REQ-026 Registered response attributes (size, unsigned, offset, split flag, pending flag) SHALL be captured at acceptance and SHALL NOT change until the response is delivered.
REQ-027 rsp_valid SHALL be a single-cycle pulse; the core SHALL NOT apply backpressure to responses.

Reset
REQ-028 While reset is high, the block SHALL drive req_ready = 0, mem_wen = 0 and rsp_valid = 0, and the next state SHALL be IDLE.
REQ-029 Reset asserted while in SECOND SHALL suppress the second access, with no write enable.
- No response is produced for the aborted load.
- The hold register value is don't-care.
REQ-030 A response pending at the reset edge SHALL be discarded: rsp_valid = 0 in the cycle after reset.

Structure
REQ-031 Package dtcm_lsu_pkg SHALL hold:
- the size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
- the state enum (IDLE, SECOND);
- the constant DTCM_WORDS = 1024.
REQ-032 The combinational store-shift/mask and load-extract/extend logic SHALL live in one sub-module, dtcm_lsu_align, instantiated once; the FSM and registers SHALL stay in dtcm_lsu.

Verification
REQ-033 Aligned word store then load: store addr 0x10 with data 0xDEADBEEF; load addr 0x10 in the next cycle.
- Required response: mem_wen = 4'b1111 on the store, and rsp_rdata = 0xDEADBEEF exactly one cycle after the load is accepted.
REQ-034 Byte loads from word 0x80 = 0x00F08000:
- lb at 0x82 -> rsp_rdata = 0xFFFFFFF0;
- lbu at 0x82 -> rsp_rdata = 0x000000F0;
- lh at 0x80 -> rsp_rdata = 0xFFFF8000.
REQ-035 Split word store of 0x11223344 at 0x23:
- cycle N: mem_wen = 4'b1000, mem_wdata[31:24] = 0x44, mem_addr = 0x20;
- cycle N+1: mem_addr = 0x24, mem_wen = 4'b0111, mem_wdata[23:0] = 0x112233, req_ready = 0.
REQ-036 Split load lw at 0x23 with word 0x20 = 0xAA000000 and word 0x24 = 0x00112233:
- rsp_valid is high only in cycle N+2;
- rsp_rdata = 0x112233AA.
REQ-037 Back-to-back aligned loads at 0x0, 0x4, 0x8 in consecutive cycles:
- req_ready stays high throughout;
- three rsp_valid pulses arrive in consecutive cycles, in order.
REQ-038 Reset in cycle N+1 of a split store at 0xFFFFFFFE:
- no second write (mem_wen = 0);
- rsp_valid = 0;
- state returns to IDLE;
- req_ready = 1 in the first cycle after reset deasserts.

Source files
------------

// File: rtl/dtcm_lsu_pkg.sv
// dtcm_lsu_pkg -- shared types and helpers for the DTCM load/store unit.
//   size_e        : access size encoding (2'd3 is reserved and behaves as word)
//   state_e       : sequencer states (IDLE, SECOND)
//   DTCM_WORDS    : depth of the tightly coupled memory in 32-bit words
//   size_bytemask : byte-enable pattern of an access at offset 0
//   size_nbytes   : number of bytes touched by an access
package dtcm_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_e;

    localparam int unsigned DTCM_WORDS = 1024;

    function automatic logic [3:0] size_bytemask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001;
            SZ_HALF: mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dtcm_lsu_align.sv
// dtcm_lsu_align -- purely combinational lane steering for the LSU.
// Store side: shifts right-justified store data and its byte mask onto the
// memory lanes of a (possibly) two-word window; reports whether the access
// straddles a word boundary.
// Load side: extracts the addressed bytes from a two-word window and
// zero/sign-extends them to 32 bits.
//   req_size_i/req_offset_i/req_wdata_i : current request attributes
//   split_o                             : access crosses into the next word
//   st_lo_*/st_hi_*                     : first/second access data and mask
//   ld_*_i                              : registered attributes and read words
//   ld_data_o                           : extended load result
module dtcm_lsu_align
    import dtcm_lsu_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_offset_i,
    input  logic [31:0] req_wdata_i,
    output logic        split_o,
    output logic [31:0] st_lo_data_o,
    output logic [31:0] st_hi_data_o,
    output logic [3:0]  st_lo_mask_o,
    output logic [3:0]  st_hi_mask_o,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_unsigned_i,
    input  logic [1:0]  ld_offset_i,
    input  logic [31:0] ld_lo_word_i,
    input  logic [31:0] ld_hi_word_i,
    output logic [31:0] ld_data_o
);

    logic [63:0] st_shift_s;
    logic [7:0]  st_mask_s;
    logic [31:0] ld_raw_s;
    logic        ld_sign_s;

    assign split_o = ({1'b0, req_offset_i} + size_nbytes(req_size_i)) > 3'd4;

    // Store window: bytes that spill past lane 3 land in the second word.
    assign st_shift_s   = {32'd0, req_wdata_i} << {req_offset_i, 3'b000};
    assign st_mask_s    = {4'd0, size_bytemask(req_size_i)} << req_offset_i;
    assign st_lo_data_o = st_shift_s[31:0];
    assign st_hi_data_o = st_shift_s[63:32];
    assign st_lo_mask_o = st_mask_s[3:0];
    assign st_hi_mask_o = st_mask_s[7:4];

    // Load window: {second word, first word} shifted down by the byte offset.
    assign ld_raw_s = 32'({ld_hi_word_i, ld_lo_word_i} >> {ld_offset_i, 3'b000});

    // Extend the extracted bytes according to size and signedness.
    always_comb begin
        ld_sign_s = 1'b0;
        case (ld_size_i)
            SZ_BYTE: begin
                ld_sign_s = ~ld_unsigned_i & ld_raw_s[7];
                ld_data_o = {{24{ld_sign_s}}, ld_raw_s[7:0]};
            end
            SZ_HALF: begin
                ld_sign_s = ~ld_unsigned_i & ld_raw_s[15];
                ld_data_o = {{16{ld_sign_s}}, ld_raw_s[15:0]};
            end
            default: begin
                ld_data_o = ld_raw_s;
            end
        endcase
    end

endmodule

// File: rtl/dtcm_lsu.sv
// dtcm_lsu -- load/store unit in front of a single-port data TCM.
// Accepts one request per cycle; accesses that straddle a word boundary take
// a second cycle (SECOND) for the following word. Non-split loads respond the
// cycle after acceptance, split loads two cycles after.
//   clk, reset                 : clock, synchronous active-high reset
//   req_*                      : core request channel (valid/ready handshake)
//   rsp_valid, rsp_rdata       : single-cycle load response, no backpressure
//   mem_addr/mem_wen/mem_wdata : TCM address, byte enables, lane-aligned data
//   mem_rdata                  : TCM read word, one cycle after mem_addr
module dtcm_lsu
    import dtcm_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic        accept_s;
    logic        split_s;
    logic [31:0] st_lo_data_s, st_hi_data_s;
    logic [3:0]  st_lo_mask_s, st_hi_mask_s;
    logic [31:0] ld_lo_word_s;

    // Second-access context captured at acceptance.
    logic [31:0] sec_addr_q;
    logic [31:0] sec_data_q;
    logic [3:0]  sec_wen_q;

    // Load response context captured at acceptance.
    logic [1:0]  rsp_size_q;
    logic        rsp_unsigned_q;
    logic [1:0]  rsp_offset_q;
    logic        rsp_split_q;
    logic        ld_pend_q;    // load accepted last cycle, first read word arriving
    logic        ld_pend2_q;   // split load, second read word arriving
    logic [31:0] hold_q;       // first read word of a split load

    dtcm_lsu_align u_align (
        .req_size_i    (req_size),
        .req_offset_i  (req_addr[1:0]),
        .req_wdata_i   (req_wdata),
        .split_o       (split_s),
        .st_lo_data_o  (st_lo_data_s),
        .st_hi_data_o  (st_hi_data_s),
        .st_lo_mask_o  (st_lo_mask_s),
        .st_hi_mask_o  (st_hi_mask_s),
        .ld_size_i     (rsp_size_q),
        .ld_unsigned_i (rsp_unsigned_q),
        .ld_offset_i   (rsp_offset_q),
        .ld_lo_word_i  (ld_lo_word_s),
        .ld_hi_word_i  (mem_rdata),
        .ld_data_o     (rsp_rdata)
    );

    // For a split load the first word sits in hold_q and the live read is
    // the second word; otherwise the live read is the only word.
    assign ld_lo_word_s = ld_pend2_q ? hold_q : mem_rdata;

    assign rsp_valid = ~reset & ((ld_pend_q & ~rsp_split_q) | ld_pend2_q);

    // Next-state, handshake and TCM port drive.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept_s  = 1'b0;
        mem_addr  = {req_addr[31:2], 2'b00};
        mem_wen   = 4'b0000;
        mem_wdata = st_lo_data_s;
        case (state_q)
            IDLE: begin
                req_ready = ~reset;
                accept_s  = req_valid & ~reset;
                mem_wen   = (accept_s && req_we) ? st_lo_mask_s : 4'b0000;
                state_d   = (accept_s && split_s) ? SECOND : IDLE;
            end
            SECOND: begin
                mem_addr  = sec_addr_q;
                mem_wdata = sec_data_q;
                // Reset aborts the trailing half of a split store.
                mem_wen   = reset ? 4'b0000 : sec_wen_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response-pending flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ld_pend_q  <= 1'b0;
            ld_pend2_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_pend_q  <= accept_s & ~req_we;
            ld_pend2_q <= ld_pend_q & rsp_split_q;
        end
    end

    // Request context and split-load hold register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sec_addr_q     <= 32'd0;
            sec_data_q     <= 32'd0;
            sec_wen_q      <= 4'b0000;
            rsp_size_q     <= 2'd0;
            rsp_unsigned_q <= 1'b0;
            rsp_offset_q   <= 2'd0;
            rsp_split_q    <= 1'b0;
            hold_q         <= 32'd0;
        end else begin
            if (accept_s) begin
                // Word address wraps modulo 2^32 for the second access.
                sec_addr_q <= {req_addr[31:2], 2'b00} + 32'd4;
                sec_data_q <= st_hi_data_s;
                sec_wen_q  <= req_we ? st_hi_mask_s : 4'b0000;
            end
            // Only loads touch the response context, so a store accepted while
            // a response is outstanding cannot disturb it.
            if (accept_s && !req_we) begin
                rsp_size_q     <= req_size;
                rsp_unsigned_q <= req_unsigned;
                rsp_offset_q   <= req_addr[1:0];
                rsp_split_q    <= split_s;
            end
            if (ld_pend_q && rsp_split_q) begin
                hold_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dtcm_lsu.sv
// tb_dtcm_lsu -- self-checking bench for dtcm_lsu. A byte-array reference
// memory and a queue of expected responses predict every cycle's handshake,
// TCM port drive and load response; a simple word-array TCM sits on the
// memory port.
module tb_dtcm_lsu;
    import dtcm_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wen;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    dtcm_lsu dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // TCM: byte-enabled write, registered read.
    logic [31:0] tcm [0:DTCM_WORDS-1];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_wen[i]) tcm[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        mem_rdata <= tcm[mem_addr[11:2]];
    end

    // Reference state.
    logic [7:0] ref_mem [0:4*DTCM_WORDS-1];
    typedef struct { int due; logic [31:0] data; } rsp_t;
    rsp_t exp_q[$];
    bit          sec_pend = 1'b0;
    logic [31:0] sec_addr, sec_data;
    logic [3:0]  sec_mask;
    logic [31:0] seen_addr, seen_wdata, seen_rdata;
    logic [3:0]  seen_wen;
    logic        seen_ready, seen_rsp_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    function automatic int nbytes_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    task automatic write_word(input logic [31:0] wa, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] ba;
        for (int i = 0; i < 4; i++) begin
            ba = {wa[31:2], 2'b00} + 32'(i);
            if (m[i]) ref_mem[ba[11:0]] = d[8*i +: 8];
        end
    endtask

    // One clock cycle: drive, predict, compare, advance the reference.
    task automatic cycle(input bit rst, input bit v, input bit we, input logic [1:0] sz,
                         input bit uns, input logic [31:0] a, input logic [31:0] wd);
        bit          exp_ready, acc, split;
        int          n, off, p;
        logic [3:0]  m1, m2;
        logic [31:0] d1, d2, v32, ba;
        rsp_t        r;
        @(negedge clk);
        reset = rst; req_valid = v; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        #1;
        seen_addr = mem_addr; seen_wen = mem_wen; seen_wdata = mem_wdata;
        seen_ready = req_ready; seen_rsp_valid = rsp_valid; seen_rdata = rsp_rdata;

        exp_ready = !rst && !sec_pend;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        acc   = v && exp_ready;
        n     = nbytes_of(sz);
        off   = int'(a[1:0]);
        split = (off + n) > 4;
        m1 = 4'd0; m2 = 4'd0; d1 = 32'd0; d2 = 32'd0;
        if (we) begin
            for (int k = 0; k < n; k++) begin
                p = off + k;
                if (p < 4) begin m1[p] = 1'b1; d1[8*p +: 8] = wd[8*k +: 8]; end
                else begin m2[p-4] = 1'b1; d2[8*(p-4) +: 8] = wd[8*k +: 8]; end
            end
        end

        if (rst) begin
            check("wen_reset", 32'(mem_wen), 32'd0);
        end else if (sec_pend) begin
            check("sec_addr", mem_addr, sec_addr);
            check("sec_wen", 32'(mem_wen), 32'(sec_mask));
            if (sec_mask != 4'd0) check("sec_wdata", mem_wdata & lanes(sec_mask), sec_data);
        end else begin
            check("wen", 32'(mem_wen), (acc && we) ? 32'(m1) : 32'd0);
            if (v) check("addr", mem_addr, {a[31:2], 2'b00});
            if (acc && we) check("wdata", mem_wdata & lanes(m1), d1);
        end

        if (!rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_rdata", rsp_rdata, exp_q[0].data);
            void'(exp_q.pop_front());
        end else begin
            check("rsp_valid", 32'(rsp_valid), 32'd0);
        end

        if (rst) begin
            exp_q.delete();
            sec_pend = 1'b0;
        end else begin
            if (sec_pend) write_word(sec_addr, sec_mask, sec_data);
            sec_pend = 1'b0;
            if (acc) begin
                if (we) begin
                    write_word(a, m1, d1);
                end else begin
                    v32 = 32'd0;
                    for (int k = 0; k < n; k++) begin
                        ba = a + 32'(k);
                        v32[8*k +: 8] = ref_mem[ba[11:0]];
                    end
                    if (n < 4 && !uns && v32[8*n-1]) v32 = v32 | ~((32'd1 << (8*n)) - 32'd1);
                    r.due = cyc + (split ? 2 : 1);
                    r.data = v32;
                    exp_q.push_back(r);
                end
                if (split) begin
                    sec_pend = 1'b1;
                    sec_addr = {a[31:2], 2'b00} + 32'd4;
                    sec_mask = m2;
                    sec_data = d2;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, 1'b1, sz, 1'b0, a, d);
    endtask

    task automatic ld(input logic [1:0] sz, input bit uns, input logic [31:0] a);
        cycle(1'b0, 1'b1, 1'b0, sz, uns, a, 32'd0);
    endtask

    initial begin
        logic [31:0] w, ra;
        bit          rr;
        for (int i = 0; i < DTCM_WORDS; i++) begin
            w = $urandom;
            tcm[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end

        cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1);

        // Aligned word store then load.
        st(2'd2, 32'h10, 32'hDEADBEEF);
        check("s033_wen", 32'(seen_wen), 32'hF);
        ld(2'd2, 1'b0, 32'h10);
        idle();
        check("r033_valid", 32'(seen_rsp_valid), 32'd1);
        check("r033_data", seen_rdata, 32'hDEADBEEF);

        // Sub-word loads, pipelined back to back.
        st(2'd2, 32'h80, 32'h00F08000);
        ld(2'd0, 1'b0, 32'h82);
        ld(2'd0, 1'b1, 32'h82);
        check("r034_lb", seen_rdata, 32'hFFFFFFF0);
        ld(2'd1, 1'b0, 32'h80);
        check("r034_lbu", seen_rdata, 32'h000000F0);
        idle();
        check("r034_lh", seen_rdata, 32'hFFFF8000);

        // Split word store; a request offered in SECOND must be ignored.
        st(2'd2, 32'h23, 32'h11223344);
        check("s035_wen0", 32'(seen_wen), 32'h8);
        check("s035_data0", 32'(seen_wdata[31:24]), 32'h44);
        check("s035_addr0", seen_addr, 32'h20);
        ld(2'd2, 1'b0, 32'h40);
        check("s035_addr1", seen_addr, 32'h24);
        check("s035_wen1", 32'(seen_wen), 32'h7);
        check("s035_data1", 32'(seen_wdata[23:0]), 32'h112233);
        check("s035_ready1", 32'(seen_ready), 32'd0);

        // Split load.
        st(2'd2, 32'h20, 32'hAA000000);
        st(2'd2, 32'h24, 32'h00112233);
        ld(2'd2, 1'b0, 32'h23);
        idle();
        check("r036_n1", 32'(seen_rsp_valid), 32'd0);
        idle();
        check("r036_n2", 32'(seen_rsp_valid), 32'd1);
        check("r036_data", seen_rdata, 32'h112233AA);

        // Back-to-back aligned loads.
        ld(2'd2, 1'b0, 32'h0);
        ld(2'd2, 1'b0, 32'h4);
        ld(2'd2, 1'b0, 32'h8);
        idle();
        idle();

        // Reset during the second half of a wrapping split store.
        st(2'd2, 32'hFFFFFFFE, 32'hCAFEF00D);
        check("s038_addr0", seen_addr, 32'hFFFFFFFC);
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        check("s038_wen", 32'(seen_wen), 32'd0);
        idle();
        check("s038_ready", 32'(seen_ready), 32'd1);
        ld(2'd2, 1'b0, 32'h0);
        idle();

        // Load pending at a reset edge is dropped.
        ld(2'd2, 1'b0, 32'h10);
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        idle();
        check("r030_drop", 32'(seen_rsp_valid), 32'd0);

        // Randomized traffic.
        for (int t = 0; t < 800; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra[11:0] = 12'hFF0 + 12'($urandom_range(0, 15));
            else ra[11:0] = 12'($urandom_range(0, 63));
            rr = ($urandom_range(0, 79) == 0);
            cycle(rr, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, ra, $urandom);
        end
        idle();
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
